// File: rtl/rr_reg_write_arbiter_if.sv
// Write-request bus between N producers and the shared-register arbiter.
// master = producer side, slave = arbiter side.
interface rr_reg_write_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [IDW-1:0]     gnt_id;
  logic [WIDTH-1:0]   q;
  logic               q_vld;
  logic               busy;

  modport master (output req, lock, wdata, input gnt, gnt_id, q, q_vld, busy);
  modport slave  (input req, lock, wdata, output gnt, gnt_id, q, q_vld, busy);
endinterface

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N writers,
// with optional bounded lock bursts by a single owner.
module rr_reg_write_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_reg_write_arbiter_if.slave bus
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW  = $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_vld_q, q_vld_d;

  logic [IDW:0]     pick;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   src;
  logic [WIDTH-1:0] src_data;

  // Index after i, wrapping at N (N need not be a power of two).
  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] i);
    if (int'(i) == int'(N) - 1) return '0;
    return IDW'(int'(i) + 1);
  endfunction

  // First set request scanning p, p+1, ... cyclically; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW:0] res;
    int           k;
    res = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      k = int'(p) + i;
      if (k >= int'(N)) k = k - int'(N);
      if (r[IDW'(k)]) res = {1'b1, IDW'(k)};
    end
    return res;
  endfunction

  assign pick     = rr_pick(bus.req, ptr_q);
  assign found    = pick[IDW];
  assign win      = pick[IDW-1:0];
  assign src      = (state_q == OWN) ? owner_q : win;
  assign src_data = bus.wdata[int'(src)*int'(WIDTH) +: WIDTH];

  // Next-state and write decision.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    q_d      = q_q;
    q_vld_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          gnt_id_d   = win;
          q_d        = src_data;
          q_vld_d    = 1'b1;
          // With MAX_LOCK==1 the single locked write is also the release.
          if (bus.lock[win] && (MAX_LOCK > 1)) begin
            state_d = OWN;
            owner_d = win;
            cnt_d   = CW'(1);
          end else begin
            ptr_d = inc_mod(win);
          end
        end
      end
      OWN: begin
        if (bus.req[owner_q]) begin
          gnt_d[owner_q] = 1'b1;
          gnt_id_d       = owner_q;
          q_d            = src_data;
          q_vld_d        = 1'b1;
          cnt_d          = cnt_q + CW'(1);
        end
        if (!bus.lock[owner_q] ||
            (bus.req[owner_q] && (cnt_q == CW'(MAX_LOCK - 1)))) begin
          state_d = IDLE;
          ptr_d   = inc_mod(owner_q);
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      q_q      <= '0;
      q_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      q_q      <= q_d;
      q_vld_q  <= q_vld_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.q      = q_q;
  assign bus.q_vld  = q_vld_q;
  assign bus.busy   = (state_q == OWN);
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Directed bench for rr_reg_write_arbiter (N=4, WIDTH=8, MAX_LOCK=8).
module tb_rr_reg_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   nw;

  rr_reg_write_arbiter_if #(.N(4), .WIDTH(8)) bus ();

  rr_reg_write_arbiter #(.N(4), .WIDTH(8), .MAX_LOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic [1:0] id,
                      input logic [7:0] qq, input logic v, input logic b);
    chk({tag, ".gnt"},    32'(bus.gnt),    32'(g));
    chk({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(id));
    chk({tag, ".q"},      32'(bus.q),      32'(qq));
    chk({tag, ".q_vld"},  32'(bus.q_vld),  32'(v));
    chk({tag, ".busy"},   32'(bus.busy),   32'(b));
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = 4'($urandom);
    bus.lock  = 4'($urandom);
    bus.wdata = 32'($urandom);
    #2;
    outs("reset", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    bus.wdata = 32'h13121110;
    bus.req   = 4'b0000;
    bus.lock  = 4'b0000;
    rst       = 1'b0;
    step();
    outs("idle", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);

    // Plain rotation with all requesters active
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      outs("rr", 4'(4'b0001 << (k % 4)), 2'(k % 4), 8'(8'h10 + k % 4), 1'b1, 1'b0);
    end

    // Fairness: after 2 wins, 3 beats 0, then 0
    bus.req = 4'b0100;
    step(); outs("fair2", 4'b0100, 2'd2, 8'h12, 1'b1, 1'b0);
    bus.req = 4'b1001;
    step(); outs("fair3", 4'b1000, 2'd3, 8'h13, 1'b1, 1'b0);
    step(); outs("fair0", 4'b0001, 2'd0, 8'h10, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step(); outs("hold", 4'b0000, 2'd0, 8'h10, 1'b0, 1'b0);
    bus.req = 4'b1000;
    step(); outs("pre_lock", 4'b1000, 2'd3, 8'h13, 1'b1, 1'b0);

    // Lock burst: 3 locked writes, release edge still writes, then 1
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step(); outs("lock", 4'b0001, 2'd0, 8'h10, 1'b1, 1'b1);
    end
    bus.lock = 4'b0000;
    step(); outs("unlock", 4'b0001, 2'd0, 8'h10, 1'b1, 1'b0);
    step(); outs("after_lock", 4'b0010, 2'd1, 8'h11, 1'b1, 1'b0);
    bus.req = 4'b1000;
    step(); outs("pre_force", 4'b1000, 2'd3, 8'h13, 1'b1, 1'b0);

    // Forced release after MAX_LOCK writes
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    nw = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.gnt == 4'b0001) nw++;
      chk("force.busy", 32'(bus.busy), 32'(k < 7));
      chk("force.q", 32'(bus.q), 32'h10);
    end
    chk("force.writes", 32'(nw), 32'd8);
    step(); outs("force_next", 4'b0010, 2'd1, 8'h11, 1'b1, 1'b0);
    step(); outs("relock", 4'b0001, 2'd0, 8'h10, 1'b1, 1'b1);

    // Owner idle while locked: others ignored, q holds
    bus.req = 4'b0010;
    step(); outs("own_idle1", 4'b0000, 2'd0, 8'h10, 1'b0, 1'b1);
    step(); outs("own_idle2", 4'b0000, 2'd0, 8'h10, 1'b0, 1'b1);

    // Async reset between edges
    #2;
    rst = 1'b1;
    #1;
    outs("rst_async", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
    step();
    rst      = 1'b0;
    bus.lock = 4'b0000;
    step(); outs("post_rst", 4'b0010, 2'd1, 8'h11, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
